// File: rtl/progmem_arbiter_if.sv
// Bus bundle between the CPU data port, the boot loader and the program memory.
// The arbiter uses the slave view; the surrounding system uses the master view.
interface progmem_arbiter_if #(
  parameter int CNT_W = 16
);
  logic             cpu_req;
  logic             cpu_wen;
  logic [29:0]      cpu_addr;
  logic [31:0]      cpu_wdata;
  logic [3:0]       cpu_be;
  logic             cpu_gnt;
  logic             cpu_rvalid;
  logic [31:0]      cpu_rdata;
  logic             cpu_stall;

  logic             ld_req;
  logic [29:0]      ld_addr;
  logic [31:0]      ld_wdata;
  logic             ld_done;
  logic             ld_gnt;
  logic [CNT_W-1:0] ld_count;

  logic             mem_ren;
  logic             mem_wen;
  logic [29:0]      mem_address;
  logic [31:0]      mem_data_in;
  logic [3:0]       mem_byte_select_vector;
  logic [31:0]      mem_data_out;

  modport slave (
    input  cpu_req, cpu_wen, cpu_addr, cpu_wdata, cpu_be,
    output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
    input  ld_req, ld_addr, ld_wdata, ld_done,
    output ld_gnt, ld_count,
    output mem_ren, mem_wen, mem_address, mem_data_in, mem_byte_select_vector,
    input  mem_data_out
  );

  modport master (
    output cpu_req, cpu_wen, cpu_addr, cpu_wdata, cpu_be,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
    output ld_req, ld_addr, ld_wdata, ld_done,
    input  ld_gnt, ld_count,
    input  mem_ren, mem_wen, mem_address, mem_data_in, mem_byte_select_vector,
    output mem_data_out
  );
endinterface

// File: rtl/progmem_arbiter.sv
// Program-memory arbiter: the loader owns the memory during BOOT, then CPU and
// loader share it round-robin in RUN. Grants and memory drive are same-cycle.
module progmem_arbiter #(
  parameter bit BOOT_ON_RESET = 1'b1,
  parameter int CNT_W         = 16
) (
  input logic              clk,
  input logic              reset,
  progmem_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t           RESET_STATE = BOOT_ON_RESET ? ST_BOOT : ST_RUN;
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic             rr_ld_r;      // 1: loader wins the next contended cycle
  logic             cpu_rvalid_r;
  logic [CNT_W-1:0] ld_count_r;

  logic             cpu_gnt_s;
  logic             ld_gnt_s;
  logic             contended_s;
  logic             stall_s;
  logic             mem_ren_s;
  logic             mem_wen_s;
  logic [29:0]      mem_address_s;
  logic [31:0]      mem_data_in_s;
  logic [3:0]       mem_be_s;

  // Grant decision; reset forces both grants low regardless of state
  always_comb begin
    cpu_gnt_s   = 1'b0;
    ld_gnt_s    = 1'b0;
    contended_s = 1'b0;
    if (reset) begin
      cpu_gnt_s   = 1'b0;
      ld_gnt_s    = 1'b0;
      contended_s = 1'b0;
    end else begin
      case (state_r)
        ST_BOOT: begin
          ld_gnt_s = bus.ld_req;
        end
        ST_RUN: begin
          contended_s = bus.cpu_req & bus.ld_req;
          if (contended_s) begin
            ld_gnt_s  = rr_ld_r;
            cpu_gnt_s = ~rr_ld_r;
          end else begin
            ld_gnt_s  = bus.ld_req;
            cpu_gnt_s = bus.cpu_req;
          end
        end
        default: begin
          cpu_gnt_s = 1'b0;
          ld_gnt_s  = 1'b0;
        end
      endcase
    end
  end

  // Memory port mux; nothing reaches mem_wen without a grant
  always_comb begin
    mem_ren_s     = 1'b0;
    mem_wen_s     = 1'b0;
    mem_address_s = 30'd0;
    mem_data_in_s = 32'd0;
    mem_be_s      = 4'b0000;
    if (ld_gnt_s) begin
      mem_wen_s     = 1'b1;
      mem_address_s = bus.ld_addr;
      mem_data_in_s = bus.ld_wdata;
      mem_be_s      = 4'b1111;
    end else if (cpu_gnt_s) begin
      mem_wen_s     = bus.cpu_wen;
      mem_ren_s     = ~bus.cpu_wen;
      mem_address_s = bus.cpu_addr;
      mem_data_in_s = bus.cpu_wdata;
      mem_be_s      = bus.cpu_be;
    end else begin
      mem_ren_s     = 1'b0;
      mem_wen_s     = 1'b0;
    end
  end

  // Stall follows the state, and the reset state while reset is held
  always_comb begin
    stall_s = 1'b0;
    if (reset) begin
      stall_s = BOOT_ON_RESET;
    end else begin
      stall_s = (state_r == ST_BOOT);
    end
  end

  // State, round-robin pointer, read-valid pipeline and loader counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= RESET_STATE;
      rr_ld_r      <= 1'b1;
      cpu_rvalid_r <= 1'b0;
      ld_count_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_BOOT: begin
          if (bus.ld_done) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_BOOT;
          end
        end
        ST_RUN:  state_r <= ST_RUN;
        default: state_r <= RESET_STATE;
      endcase

      if (contended_s) begin
        rr_ld_r <= ~rr_ld_r;
      end

      cpu_rvalid_r <= cpu_gnt_s & ~bus.cpu_wen;

      if (ld_gnt_s && (ld_count_r != CNT_MAX)) begin
        ld_count_r <= ld_count_r + CNT_ONE;
      end
    end
  end

  assign bus.cpu_gnt                = cpu_gnt_s;
  assign bus.ld_gnt                 = ld_gnt_s;
  assign bus.cpu_stall              = stall_s;
  assign bus.cpu_rvalid             = cpu_rvalid_r;
  assign bus.cpu_rdata              = cpu_rvalid_r ? bus.mem_data_out : 32'h0000_0000;
  assign bus.ld_count               = ld_count_r;
  assign bus.mem_ren                = mem_ren_s;
  assign bus.mem_wen                = mem_wen_s;
  assign bus.mem_address            = mem_address_s;
  assign bus.mem_data_in            = mem_data_in_s;
  assign bus.mem_byte_select_vector = mem_be_s;

endmodule

// File: tb/tb_progmem_arbiter.sv
// Bench for progmem_arbiter: two instances (boot-on-reset 16-bit counter, run-on-reset
// 2-bit counter) share one stimulus stream and are compared against a rule-level model.
module tb_progmem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_wen;
  logic [29:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_be;
  logic        ld_req, ld_done;
  logic [29:0] ld_addr;
  logic [31:0] ld_wdata;
  logic [31:0] mem_dout;

  int total = 0;
  int bad   = 0;

  progmem_arbiter_if #(.CNT_W(16)) bus0 ();
  progmem_arbiter_if #(.CNT_W(2))  bus1 ();

  progmem_arbiter #(.BOOT_ON_RESET(1'b1), .CNT_W(16)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  progmem_arbiter #(.BOOT_ON_RESET(1'b0), .CNT_W(2))  dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  assign bus0.cpu_req = cpu_req;   assign bus1.cpu_req = cpu_req;
  assign bus0.cpu_wen = cpu_wen;   assign bus1.cpu_wen = cpu_wen;
  assign bus0.cpu_addr = cpu_addr; assign bus1.cpu_addr = cpu_addr;
  assign bus0.cpu_wdata = cpu_wdata; assign bus1.cpu_wdata = cpu_wdata;
  assign bus0.cpu_be = cpu_be;     assign bus1.cpu_be = cpu_be;
  assign bus0.ld_req = ld_req;     assign bus1.ld_req = ld_req;
  assign bus0.ld_addr = ld_addr;   assign bus1.ld_addr = ld_addr;
  assign bus0.ld_wdata = ld_wdata; assign bus1.ld_wdata = ld_wdata;
  assign bus0.ld_done = ld_done;   assign bus1.ld_done = ld_done;
  assign bus0.mem_data_out = mem_dout; assign bus1.mem_data_out = mem_dout;

  logic        o_cgnt[2], o_lgnt[2], o_stall[2], o_ren[2], o_wen[2], o_rv[2];
  logic [3:0]  o_be[2];
  logic [29:0] o_addr[2];
  logic [31:0] o_din[2], o_rdata[2];
  logic [15:0] o_cnt[2];

  assign o_cgnt[0] = bus0.cpu_gnt;    assign o_cgnt[1] = bus1.cpu_gnt;
  assign o_lgnt[0] = bus0.ld_gnt;     assign o_lgnt[1] = bus1.ld_gnt;
  assign o_stall[0] = bus0.cpu_stall; assign o_stall[1] = bus1.cpu_stall;
  assign o_ren[0] = bus0.mem_ren;     assign o_ren[1] = bus1.mem_ren;
  assign o_wen[0] = bus0.mem_wen;     assign o_wen[1] = bus1.mem_wen;
  assign o_rv[0] = bus0.cpu_rvalid;   assign o_rv[1] = bus1.cpu_rvalid;
  assign o_be[0] = bus0.mem_byte_select_vector; assign o_be[1] = bus1.mem_byte_select_vector;
  assign o_addr[0] = bus0.mem_address; assign o_addr[1] = bus1.mem_address;
  assign o_din[0] = bus0.mem_data_in;  assign o_din[1] = bus1.mem_data_in;
  assign o_rdata[0] = bus0.cpu_rdata;  assign o_rdata[1] = bus1.cpu_rdata;
  assign o_cnt[0] = bus0.ld_count;     assign o_cnt[1] = {14'd0, bus1.ld_count};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, one slot per instance
  bit boot_on_reset[2] = '{1'b1, 1'b0};
  int count_max[2]     = '{65535, 3};
  bit m_boot[2];
  bit m_cpu_won_last[2];   // reset value means the loader is favoured
  int m_cnt[2];
  bit m_rv[2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_boot[i]         = boot_on_reset[i];
      m_cpu_won_last[i] = 1'b1;
      m_cnt[i]          = 0;
      m_rv[i]           = 1'b0;
    end
  endtask

  task automatic idle();
    cpu_req = 1'b0; cpu_wen = 1'b0; cpu_addr = 30'd0; cpu_wdata = 32'd0; cpu_be = 4'b0000;
    ld_req = 1'b0; ld_addr = 30'd0; ld_wdata = 32'd0; ld_done = 1'b0;
  endtask

  // One clock: called at posedge+1 with inputs already set
  task automatic tick();
    bit eg_l[2], eg_c[2];
    #2;
    if (reset) model_reset();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        eg_l[i] = 1'b0; eg_c[i] = 1'b0;
      end else if (m_boot[i]) begin
        eg_l[i] = ld_req; eg_c[i] = 1'b0;
      end else if (cpu_req && ld_req) begin
        eg_l[i] = m_cpu_won_last[i]; eg_c[i] = !m_cpu_won_last[i];
      end else begin
        eg_l[i] = ld_req; eg_c[i] = cpu_req;
      end
      check($sformatf("cpu_gnt%0d", i), 64'(o_cgnt[i]), 64'(eg_c[i]));
      check($sformatf("ld_gnt%0d", i), 64'(o_lgnt[i]), 64'(eg_l[i]));
      check($sformatf("stall%0d", i), 64'(o_stall[i]), 64'(m_boot[i]));
      check($sformatf("mem_ren%0d", i), 64'(o_ren[i]), 64'(eg_c[i] && !cpu_wen));
      check($sformatf("mem_wen%0d", i), 64'(o_wen[i]), 64'(eg_l[i] || (eg_c[i] && cpu_wen)));
      check($sformatf("mem_be%0d", i), 64'(o_be[i]), eg_l[i] ? 64'hF : (eg_c[i] ? 64'(cpu_be) : 64'h0));
      check($sformatf("mem_addr%0d", i), 64'(o_addr[i]), eg_l[i] ? 64'(ld_addr) : (eg_c[i] ? 64'(cpu_addr) : 64'h0));
      check($sformatf("mem_din%0d", i), 64'(o_din[i]), eg_l[i] ? 64'(ld_wdata) : (eg_c[i] ? 64'(cpu_wdata) : 64'h0));
      check($sformatf("rvalid%0d", i), 64'(o_rv[i]), 64'(m_rv[i]));
      check($sformatf("rdata%0d", i), 64'(o_rdata[i]), m_rv[i] ? 64'(mem_dout) : 64'h0);
      check($sformatf("ld_count%0d", i), 64'(o_cnt[i]), 64'(m_cnt[i]));
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        if (eg_l[i] && m_cnt[i] < count_max[i]) m_cnt[i]++;
        m_rv[i] = eg_c[i] && !cpu_wen;
        if (!m_boot[i] && cpu_req && ld_req) m_cpu_won_last[i] = eg_c[i];
        if (m_boot[i] && ld_done) m_boot[i] = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    logic [31:0] img[3];
    img[0] = 32'hAAAA_0001; img[1] = 32'hBBBB_0002; img[2] = 32'hCCCC_0003;
    idle();
    reset = 1'b1;
    mem_dout = 32'd0;
    model_reset();
    @(posedge clk);
    #1;
    tick(); tick();
    reset = 1'b0;

    // Boot image load
    for (int k = 0; k < 3; k++) begin
      ld_req = 1'b1; ld_addr = 30'(k); ld_wdata = img[k];
      tick();
    end
    ld_req = 1'b0;

    // CPU held off while booting
    cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 30'h10; cpu_be = 4'b1111;
    repeat (5) tick();
    check("boot_count", 64'(o_cnt[0]), 64'd3);
    check("boot_stall", 64'(o_stall[0]), 64'd1);
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    check("run_stall", 64'(o_stall[0]), 64'd0);
    tick();
    cpu_req = 1'b0;
    tick();

    // Contention: LD, CPU, LD, CPU
    cpu_req = 1'b1; cpu_wen = 1'b1; cpu_wdata = 32'h1234_5678; cpu_addr = 30'h20; cpu_be = 4'b0011;
    ld_req = 1'b1; ld_addr = 30'h30; ld_wdata = 32'h9ABC_DEF0;
    repeat (4) tick();
    idle();

    // Read latency
    cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 30'h800; cpu_be = 4'b1111;
    tick();
    cpu_req = 1'b0; mem_dout = 32'hDEAD_BEEF;
    tick();
    tick();

    // Reset in the cycle after a read grant
    cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 30'h44;
    tick();
    cpu_req = 1'b0; reset = 1'b1;
    tick();
    check("rst_rvalid", 64'(o_rv[0]), 64'd0);
    check("rst_count", 64'(o_cnt[0]), 64'd0);
    reset = 1'b0;

    // Counter saturation on the 2-bit instance
    ld_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ld_addr = 30'(k + 8); ld_wdata = $urandom;
      tick();
    end
    check("sat_count", 64'(o_cnt[1]), 64'd3);
    check("sat_count_wide", 64'(o_cnt[0]), 64'd5);

    // ld_done together with a loader write
    ld_done = 1'b1; ld_addr = 30'h5;
    tick();
    idle();
    check("done_write_count", 64'(o_cnt[0]), 64'd6);
    check("done_write_stall", 64'(o_stall[0]), 64'd0);
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    check("done_in_run_stall", 64'(o_stall[0]), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 79) == 0);
      cpu_req   = 1'($urandom_range(0, 1));
      cpu_wen   = 1'($urandom_range(0, 1));
      cpu_addr  = 30'($urandom);
      cpu_wdata = $urandom;
      cpu_be    = 4'($urandom);
      ld_req    = 1'($urandom_range(0, 1));
      ld_addr   = 30'($urandom);
      ld_wdata  = $urandom;
      ld_done   = ($urandom_range(0, 15) == 0);
      mem_dout  = $urandom;
      tick();
    end
    reset = 1'b0;
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
